// File: rtl/main_memory_responder_pkg.sv
// Shared types and defaults for the cache-miss memory responder and its request FIFO.
package main_memory_responder_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int ICACHE_LINE_WIDTH   = 128;
    localparam int ICACHE_LINE_OFFSET  = 4;
    localparam int DEFAULT_MEM_LINES   = 4096;
    localparam int DEFAULT_MEM_LATENCY = 10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        addr;
        logic                         is_store;
        logic [ICACHE_LINE_WIDTH-1:0] data;
    } memory_request_t;

endpackage

// File: rtl/main_memory_responder_mem_req_fifo.sv
// Synchronous FIFO of miss requests; pointers carry an extra wrap bit to tell full from empty.
module mem_req_fifo
    import main_memory_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  memory_request_t push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output memory_request_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]  wr_ptr_r;
    logic [PTR_W:0]  rd_ptr_r;
    memory_request_t slots_r [DEPTH];
    logic            push_en_s;
    logic            pop_en_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign pop_en_s  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is then accepted.
    assign push_en_s = push && (!full || pop_en_s);
    assign head      = slots_r[rd_ptr_r[PTR_W-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (push_en_s) begin
            slots_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side end of the cache miss interface: queues line requests, serves them in order
// after a fixed latency, returning read lines and absorbing stores silently.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int MEM_LINES      = DEFAULT_MEM_LINES,
    parameter int LATENCY        = DEFAULT_MEM_LATENCY,
    parameter int REQ_FIFO_DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid_miss,
    input  memory_request_t              req_info_miss,
    output logic                         rsp_valid_miss,
    output logic [ICACHE_LINE_WIDTH-1:0] rsp_data_miss,
    output logic                         req_overflow
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(LATENCY);
    // Pop edge and DONE-entry edge each account for one cycle of the latency.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_rsp_state_t;

    mem_rsp_state_t               state_r;
    mem_rsp_state_t               state_s;
    logic [CNT_W-1:0]             cnt_r;
    logic [CNT_W-1:0]             cnt_s;
    logic                         pop_s;
    logic                         access_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    memory_request_t              fifo_head_s;
    logic                         unused_head_addr_s;
    logic [IDX_W-1:0]             active_idx_r;
    logic                         active_store_r;
    logic [ICACHE_LINE_WIDTH-1:0] active_data_r;
    logic [ICACHE_LINE_WIDTH-1:0] mem_r [MEM_LINES];
    logic                         rsp_valid_r;
    logic [ICACHE_LINE_WIDTH-1:0] rsp_data_r;
    logic                         overflow_r;

    function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ICACHE_LINE_OFFSET +: IDX_W];
    endfunction

    mem_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_valid_miss),
        .push_data (req_info_miss),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

    assign unused_head_addr_s = ^fifo_head_s.addr;

    // Next-state, counter and pop/access strobes.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        pop_s    = 1'b0;
        access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    cnt_s   = CNT_LOAD;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == '0) begin
                    access_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    cnt_s   = CNT_LOAD;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, latency counter and the active request register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            active_idx_r   <= '0;
            active_store_r <= 1'b0;
            active_data_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (pop_s) begin
                active_idx_r   <= line_index(fifo_head_s.addr);
                active_store_r <= fifo_head_s.is_store;
                active_data_r  <= fifo_head_s.data;
            end
        end
    end

    // Backing array write port; a reset on the access edge suppresses the store.
    always_ff @(posedge clock) begin
        if (!reset && access_s && active_store_r) begin
            mem_r[active_idx_r] <= active_data_r;
        end
    end

    // Registered response and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            overflow_r  <= 1'b0;
        end else begin
            rsp_valid_r <= access_s && !active_store_r;
            if (access_s && !active_store_r) begin
                rsp_data_r <= mem_r[active_idx_r];
            end
            if (req_valid_miss && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign rsp_valid_miss = rsp_valid_r;
    assign rsp_data_miss  = rsp_data_r;
    assign req_overflow   = overflow_r;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, ordering, overflow, wrap and reset cases.
module tb_main_memory_responder;
    import main_memory_responder_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid_miss;
    memory_request_t req_info_miss;
    logic            rsp_valid_miss;
    logic [127:0]    rsp_data_miss;
    logic            req_overflow;

    int           vec = 0;
    int           miscompares = 0;
    logic [127:0] last_data;

    localparam logic [127:0] D5    = {16{8'hA5}};
    localparam logic [127:0] DBEEF = 128'hDEAD_BEEF;
    localparam logic [127:0] D1    = {4{32'h1111_1111}};
    localparam logic [127:0] D2    = {4{32'h2222_2222}};
    localparam logic [127:0] D7    = {4{32'h7777_7777}};
    localparam logic [127:0] DJUNK = {4{32'hBAD0_BAD0}};
    localparam logic [127:0] Z128  = 128'd0;

    always #5 clock = ~clock;

    main_memory_responder dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid_miss (req_valid_miss),
        .req_info_miss  (req_info_miss),
        .rsp_valid_miss (rsp_valid_miss),
        .rsp_data_miss  (rsp_data_miss),
        .req_overflow   (req_overflow)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] addr, input logic st, input logic [127:0] d);
        req_valid_miss = 1'b1;
        req_info_miss  = '{addr: addr, is_store: st, data: d};
        step();
        req_valid_miss = 1'b0;
    endtask

    // Steps n cycles; a pulse is expected only at offsets a0/a1/a2, data must hold otherwise.
    task automatic observe(input string tag, input int n,
                           input int a0 = -1, input logic [127:0] d0 = 128'd0,
                           input int a1 = -1, input logic [127:0] d1 = 128'd0,
                           input int a2 = -1, input logic [127:0] d2 = 128'd0);
        logic hit;
        for (int i = 1; i <= n; i++) begin
            step();
            hit = (i == a0) || (i == a1) || (i == a2);
            if (i == a0) last_data = d0;
            else if (i == a1) last_data = d1;
            else if (i == a2) last_data = d2;
            chk($sformatf("%s valid +%0d", tag, i), {127'd0, rsp_valid_miss}, {127'd0, hit});
            chk($sformatf("%s data +%0d", tag, i), rsp_data_miss, last_data);
        end
    endtask

    initial begin
        reset          = 1'b1;
        req_valid_miss = 1'b0;
        req_info_miss  = '0;
        last_data      = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset valid", {127'd0, rsp_valid_miss}, Z128);
        chk("reset data", rsp_data_miss, Z128);
        chk("reset ovf", {127'd0, req_overflow}, Z128);

        // 1: single read of line 5
        send(32'h50, 1'b1, D5);
        observe("t1 store", 12);
        send(32'h50, 1'b0, Z128);
        observe("t1 read", 20, 10, D5);

        // 2: store then read of line 3 queued behind it
        send(32'h30, 1'b1, DBEEF);
        send(32'h30, 1'b0, Z128);
        observe("t2", 22, 19, DBEEF);

        // 3: back-to-back reads of lines 1 and 2
        send(32'h10, 1'b1, D1);
        send(32'h20, 1'b1, D2);
        observe("t3 store", 22);
        send(32'h10, 1'b0, Z128);
        send(32'h20, 1'b0, Z128);
        observe("t3", 22, 9, D1, 19, D2);
        chk("t3 ovf", {127'd0, req_overflow}, Z128);

        // 4: one active plus three more reads, the last one is dropped
        send(32'h50, 1'b0, Z128);
        send(32'h10, 1'b0, Z128);
        send(32'h20, 1'b0, Z128);
        chk("t4 full no ovf", {127'd0, req_overflow}, Z128);
        send(32'h30, 1'b0, Z128);
        chk("t4 ovf set", {127'd0, req_overflow}, {127'd0, 1'b1});
        observe("t4", 40, 7, D5, 17, D1, 27, D2);
        chk("t4 ovf sticky", {127'd0, req_overflow}, {127'd0, 1'b1});

        // 4b: push into a full FIFO on the same cycle as a pop is accepted
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_data = '0;
        chk("t4b ovf cleared", {127'd0, req_overflow}, Z128);
        send(32'h50, 1'b0, Z128);
        send(32'h10, 1'b0, Z128);
        send(32'h20, 1'b0, Z128);
        observe("t4b pre", 8, 8, D5);
        send(32'h30, 1'b0, Z128);
        observe("t4b", 32, 9, D1, 19, D2, 29, DBEEF);
        chk("t4b no ovf", {127'd0, req_overflow}, Z128);

        // 5: wrapped address and ignored offset bits both reach line 7
        send(32'h70, 1'b1, D7);
        observe("t5 store", 12);
        send(32'h0001_0070, 1'b0, Z128);
        observe("t5 wrap", 14, 10, D7);
        send(32'h7C, 1'b0, Z128);
        observe("t5 offset", 12, 10, D7);

        // 6: reset mid-read, then reset mid-store, then a fresh read
        send(32'h50, 1'b0, Z128);
        observe("t6 pre", 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_data = '0;
        observe("t6 post", 20);
        send(32'h70, 1'b1, DJUNK);
        observe("t6 st pre", 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        observe("t6 st post", 20);
        send(32'h70, 1'b0, Z128);
        observe("t6 fresh", 14, 10, D7);
        chk("t6 ovf", {127'd0, req_overflow}, Z128);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
